// File: rtl/adma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adma_pkg
// Description : Shared burst encodings, AXI limits and write-generator FSM
//               states for the AXI DMA datamover.
// Revision    : 1.0 - initial release
// ============================================================================
package adma_pkg;

    localparam logic [1:0] ADMA_BURST_FIXED     = 2'b00;
    localparam logic [1:0] ADMA_BURST_INCR      = 2'b01;
    localparam int         ADMA_4K_BOUNDARY     = 4096;
    localparam int         ADMA_FIXED_MAX_BEATS = 16;

    typedef enum logic [1:0] {
        ADMA_ST_IDLE  = 2'd0,
        ADMA_ST_CALC  = 2'd1,
        ADMA_ST_ISSUE = 2'd2
    } adma_atxgen_st_e;

    // Only FIXED is kept as-is; every other code behaves as INCR.
    function automatic logic [1:0] adma_norm_burst(input logic [1:0] burst);
        return (burst == ADMA_BURST_FIXED) ? ADMA_BURST_FIXED : ADMA_BURST_INCR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adma_dm_wr_atx_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : adma_dm_wr_atx_gen_if
// Description : Descriptor input, AXI write burst output and completion
//               signals of the write-side burst generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface adma_dm_wr_atx_gen_if #(
    parameter int DMA_CHN_NUM = 4,
    parameter int DST_ADDR_W  = 32,
    parameter int MST_ID_W    = 5,
    parameter int ATX_LEN_W   = 8,
    parameter int DESC_BEAT_W = 16
);
    localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;

    logic [DMA_CHN_NUM_W-1:0] desc_chn_id;
    logic [MST_ID_W-1:0]      desc_id;
    logic [DST_ADDR_W-1:0]    desc_addr;
    logic [DESC_BEAT_W-1:0]   desc_beats;
    logic [1:0]               desc_burst;
    logic                     desc_vld;
    logic                     desc_rdy;

    logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
    logic [MST_ID_W-1:0]      atx_awid;
    logic [DST_ADDR_W-1:0]    atx_awaddr;
    logic [ATX_LEN_W-1:0]     atx_awlen;
    logic [1:0]               atx_awburst;
    logic                     atx_vld;
    logic                     atx_rdy;

    logic                     desc_done;
    logic [DMA_CHN_NUM_W-1:0] desc_done_chn;
    logic                     busy;

    modport master (
        input  desc_chn_id, desc_id, desc_addr, desc_beats, desc_burst, desc_vld, atx_rdy,
        output desc_rdy, atx_chn_id, atx_awid, atx_awaddr, atx_awlen, atx_awburst, atx_vld,
        output desc_done, desc_done_chn, busy
    );

    modport slave (
        output desc_chn_id, desc_id, desc_addr, desc_beats, desc_burst, desc_vld, atx_rdy,
        input  desc_rdy, atx_chn_id, atx_awid, atx_awaddr, atx_awlen, atx_awburst, atx_vld,
        input  desc_done, desc_done_chn, busy
    );

endinterface
`default_nettype wire

// File: rtl/adma_dm_burst_len_calc.sv
`default_nettype none
// ============================================================================
// Module      : adma_dm_burst_len_calc
// Description : Next burst length = min(remaining beats, max burst length,
//               beats left before the 4 KB boundary). The boundary term exists
//               only when ADMA_ATX_4K_BOUNDARY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module adma_dm_burst_len_calc
    import adma_pkg::*;
#(
    parameter int ATX_LEN_W        = 8,
    parameter int DESC_BEAT_W      = 16,
    parameter int ATX_DST_BYTE_AMT = 32
) (
    input  logic [DESC_BEAT_W-1:0] rem,
    input  logic [11:0]            addr_lo,
    input  logic                   is_fixed,
    output logic [ATX_LEN_W:0]     blen
);

    localparam int BLEN_W     = ATX_LEN_W + 1;
    localparam int CMP_A      = (DESC_BEAT_W > BLEN_W) ? DESC_BEAT_W : BLEN_W;
    localparam int CMP_W      = (CMP_A > 13) ? CMP_A : 13;
    localparam int BYTE_SHIFT = $clog2(ATX_DST_BYTE_AMT);

    localparam logic [BLEN_W-1:0] INCR_MAX  = BLEN_W'(1) << ATX_LEN_W;
    localparam logic [BLEN_W-1:0] FIXED_MAX = BLEN_W'(ADMA_FIXED_MAX_BEATS);

    logic [BLEN_W-1:0] w_max_beats;
    logic [BLEN_W-1:0] w_lim;

    assign w_max_beats = is_fixed ? FIXED_MAX : INCR_MAX;

`ifdef ADMA_ATX_4K_BOUNDARY_EN
    logic [12:0] w_bnd_bytes;
    logic [12:0] w_bnd_beats;

    // Address is beat-aligned, so the distance to the boundary is never zero.
    assign w_bnd_bytes = 13'(ADMA_4K_BOUNDARY) - {1'b0, addr_lo};
    assign w_bnd_beats = w_bnd_bytes >> BYTE_SHIFT;

    always_comb begin
        w_lim = w_max_beats;
        if (!is_fixed && (CMP_W'(w_bnd_beats) < CMP_W'(w_max_beats))) begin
            w_lim = BLEN_W'(w_bnd_beats);
        end
    end
`else
    logic unused_addr_lo;

    assign unused_addr_lo = ^addr_lo;
    assign w_lim          = w_max_beats;
`endif

    assign blen = (CMP_W'(rem) < CMP_W'(w_lim)) ? BLEN_W'(rem) : w_lim;

endmodule
`default_nettype wire

// File: rtl/adma_dm_wr_atx_gen.sv
`default_nettype none
// ============================================================================
// Module      : adma_dm_wr_atx_gen
// Description : Splits one write descriptor into legal AXI write bursts.
//               Build option: ADMA_ATX_4K_BOUNDARY_EN keeps INCR bursts
//               inside 4 KB address windows.
// Revision    : 1.0 - initial release
// ============================================================================
module adma_dm_wr_atx_gen
    import adma_pkg::*;
#(
    parameter int DMA_CHN_NUM      = 4,
    parameter int DST_ADDR_W       = 32,
    parameter int MST_ID_W         = 5,
    parameter int ATX_LEN_W        = 8,
    parameter int ATX_DST_DATA_W   = 256,
    parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
    parameter int DESC_BEAT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    adma_dm_wr_atx_gen_if.master  bus
);

    localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;
    localparam int BLEN_W        = ATX_LEN_W + 1;
    localparam int BYTE_SHIFT    = $clog2(ATX_DST_BYTE_AMT);

    localparam logic [DST_ADDR_W-1:0] ADDR_LO_MASK = DST_ADDR_W'(ATX_DST_BYTE_AMT - 1);

    adma_atxgen_st_e          r_state,   w_state_nxt;
    logic [DMA_CHN_NUM_W-1:0] r_cur_chn, w_cur_chn_nxt;
    logic [MST_ID_W-1:0]      r_cur_id,  w_cur_id_nxt;
    logic [DST_ADDR_W-1:0]    r_cur_addr, w_cur_addr_nxt;
    logic [1:0]               r_cur_burst, w_cur_burst_nxt;
    logic [DESC_BEAT_W-1:0]   r_rem,     w_rem_nxt;

    logic [DMA_CHN_NUM_W-1:0] r_atx_chn,   w_atx_chn_nxt;
    logic [MST_ID_W-1:0]      r_atx_id,    w_atx_id_nxt;
    logic [DST_ADDR_W-1:0]    r_atx_addr,  w_atx_addr_nxt;
    logic [ATX_LEN_W-1:0]     r_atx_len,   w_atx_len_nxt;
    logic [1:0]               r_atx_burst, w_atx_burst_nxt;

    logic [BLEN_W-1:0]        w_blen;
    logic [BLEN_W-1:0]        w_blen_m1;
    logic [BLEN_W-1:0]        w_iss_beats;
    logic                     w_is_fixed;

    assign w_is_fixed  = (r_cur_burst == ADMA_BURST_FIXED);
    assign w_blen_m1   = w_blen - BLEN_W'(1);
    // Beats of the burst in flight, recovered from the registered AWLEN.
    assign w_iss_beats = BLEN_W'(r_atx_len) + BLEN_W'(1);

    adma_dm_burst_len_calc #(
        .ATX_LEN_W        (ATX_LEN_W),
        .DESC_BEAT_W      (DESC_BEAT_W),
        .ATX_DST_BYTE_AMT (ATX_DST_BYTE_AMT)
    ) u_len_calc (
        .rem      (r_rem),
        .addr_lo  (r_cur_addr[11:0]),
        .is_fixed (w_is_fixed),
        .blen     (w_blen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ADMA_ST_IDLE;
            r_cur_chn   <= '0;
            r_cur_id    <= '0;
            r_cur_addr  <= '0;
            r_cur_burst <= '0;
            r_rem       <= '0;
            r_atx_chn   <= '0;
            r_atx_id    <= '0;
            r_atx_addr  <= '0;
            r_atx_len   <= '0;
            r_atx_burst <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_chn   <= w_cur_chn_nxt;
            r_cur_id    <= w_cur_id_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_cur_burst <= w_cur_burst_nxt;
            r_rem       <= w_rem_nxt;
            r_atx_chn   <= w_atx_chn_nxt;
            r_atx_id    <= w_atx_id_nxt;
            r_atx_addr  <= w_atx_addr_nxt;
            r_atx_len   <= w_atx_len_nxt;
            r_atx_burst <= w_atx_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_chn_nxt   = r_cur_chn;
        w_cur_id_nxt    = r_cur_id;
        w_cur_addr_nxt  = r_cur_addr;
        w_cur_burst_nxt = r_cur_burst;
        w_rem_nxt       = r_rem;
        w_atx_chn_nxt   = r_atx_chn;
        w_atx_id_nxt    = r_atx_id;
        w_atx_addr_nxt  = r_atx_addr;
        w_atx_len_nxt   = r_atx_len;
        w_atx_burst_nxt = r_atx_burst;

        case (r_state)
            ADMA_ST_IDLE: begin
                if (bus.desc_vld) begin
                    w_cur_chn_nxt   = bus.desc_chn_id;
                    w_cur_id_nxt    = bus.desc_id;
                    w_cur_addr_nxt  = bus.desc_addr & ~ADDR_LO_MASK;
                    w_cur_burst_nxt = adma_norm_burst(bus.desc_burst);
                    w_rem_nxt       = bus.desc_beats;
                    w_state_nxt     = ADMA_ST_CALC;
                end
            end
            ADMA_ST_CALC: begin
                if (r_rem == '0) begin
                    w_state_nxt = ADMA_ST_IDLE;
                end else begin
                    w_atx_chn_nxt   = r_cur_chn;
                    w_atx_id_nxt    = r_cur_id;
                    w_atx_addr_nxt  = r_cur_addr;
                    w_atx_len_nxt   = w_blen_m1[ATX_LEN_W-1:0];
                    w_atx_burst_nxt = r_cur_burst;
                    w_state_nxt     = ADMA_ST_ISSUE;
                end
            end
            ADMA_ST_ISSUE: begin
                if (bus.atx_rdy) begin
                    w_rem_nxt = r_rem - DESC_BEAT_W'(w_iss_beats);
                    if (!w_is_fixed) begin
                        w_cur_addr_nxt = r_cur_addr + (DST_ADDR_W'(w_iss_beats) << BYTE_SHIFT);
                    end
                    w_state_nxt = ADMA_ST_CALC;
                end
            end
            default: begin
                w_state_nxt = ADMA_ST_IDLE;
            end
        endcase
    end

    // rst gates the handshake/pulse outputs so nothing is advertised in a reset cycle.
    assign bus.desc_rdy      = (r_state == ADMA_ST_IDLE) && !rst;
    assign bus.desc_done     = (r_state == ADMA_ST_CALC) && (r_rem == '0) && !rst;
    assign bus.desc_done_chn = r_cur_chn;
    assign bus.busy          = (r_state != ADMA_ST_IDLE);

    assign bus.atx_vld       = (r_state == ADMA_ST_ISSUE);
    assign bus.atx_chn_id    = r_atx_chn;
    assign bus.atx_awid      = r_atx_id;
    assign bus.atx_awaddr    = r_atx_addr;
    assign bus.atx_awlen     = r_atx_len;
    assign bus.atx_awburst   = r_atx_burst;

endmodule
`default_nettype wire
